// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Checksum support is selected with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [31:0] WR_ADDR_RST = 32'h0000_1000;
  localparam int          BYTE_LANES  = 4;

  function automatic logic [31:0] word_addr(
    input logic [31:0] base,
    input logic [15:0] idx
  );
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// Little-endian 8-to-32 assembler: first byte lands in bits [7:0].
// Pulses word_valid for one cycle after the fourth byte is taken.
module byte_to_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_fire,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_valid,
  output logic [1:0]  lane
);

  localparam logic [1:0] LAST_LANE = 2'(BYTE_LANES - 1);

  logic [23:0] shreg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane       <= '0;
      shreg      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= in_fire && (lane == LAST_LANE);
      if (clear) begin
        lane  <= '0;
        shreg <= '0;
      end else if (in_fire) begin
        lane  <= lane + 2'd1;
        shreg <= {in_byte, shreg[23:8]};
        if (lane == LAST_LANE)
          word <= {in_byte, shreg};
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> instruction-memory words, holds cpu in reset.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = WR_ADDR_RST,
  parameter int          DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_rst,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH_WORDS);
  localparam logic [1:0]  LAST_LANE = 2'(BYTE_LANES - 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CHECK;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t      state;
  state_t      state_next;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] index;
  logic [15:0] index_next;
  logic [15:0] len_in;
  logic [1:0]  lane;
  logic        fire;
  logic        start_load;
  logic        last_byte;
  logic        last_word;
  logic        last_pend;
  logic        rdy_next;
  logic        word_valid;
  logic [31:0] word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign fire       = in_valid && in_ready;
  assign len_in     = {in_data, len_lo};
  assign start_load = start && (state == S_IDLE ||
                                state == S_DONE ||
                                state == S_ERR);
  assign last_byte  = fire && (state == S_DATA) &&
                      (lane == LAST_LANE) &&
                      (index == len - 16'd1);
  assign last_word  = word_valid && (state == S_DATA) &&
                      (index == len - 16'd1);
  assign index_next = last_word ? 16'd0 : index + 16'd1;

  assign wr_en   = word_valid;
  assign wr_data = word;

  byte_to_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_load),
    .in_fire    (fire && (state == S_DATA)),
    .in_byte    (in_data),
    .word       (word),
    .word_valid (word_valid),
    .lane       (lane)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (start) state_next = S_LEN_LO;
      S_LEN_LO: if (fire) state_next = S_LEN_HI;
      S_LEN_HI: begin
        if (fire) begin
          if ({1'b0, len_in} > DEPTH_LIM)
            state_next = S_ERR;
          else if (len_in == 16'd0)
            state_next = S_TAIL;
          else
            state_next = S_DATA;
        end
      end
      // Leave DATA only once the final word's write strobe has been issued.
      S_DATA:   if (last_word) state_next = S_TAIL;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (fire)
          state_next = (in_data == csum) ? S_DONE : S_ERR;
      end
`endif
      S_DONE:   if (start) state_next = S_LEN_LO;
      S_ERR:    if (start) state_next = S_LEN_LO;
      default:  state_next = S_IDLE;
    endcase
  end

  // Ready is held low for one cycle on entry to LEN_LO and after the last payload byte.
  always_comb begin
    rdy_next = 1'b0;
    unique case (state_next)
      S_LEN_LO: rdy_next = (state == S_LEN_LO);
      S_LEN_HI: rdy_next = 1'b1;
      S_DATA:   rdy_next = !last_byte && !last_pend;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK:  rdy_next = 1'b1;
`endif
      default:  rdy_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      len_lo     <= '0;
      len        <= '0;
      index      <= '0;
      last_pend  <= 1'b0;
      in_ready   <= 1'b0;
      wr_addr    <= BASE_ADDR;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
    end else begin
      state    <= state_next;
      in_ready <= rdy_next;
      done     <= (state_next == S_DONE);
      error    <= (state_next == S_ERR);
      cpu_rst  <= (state_next != S_DONE);

      if (state == S_LEN_LO && fire)
        len_lo <= in_data;
      if (state == S_LEN_HI && fire)
        len <= len_in;

      if (start_load) begin
        index      <= '0;
        word_count <= '0;
        wr_addr    <= BASE_ADDR;
        last_pend  <= 1'b0;
      end else begin
        if (word_valid && state == S_DATA) begin
          index      <= index_next;
          word_count <= word_count + 16'd1;
          wr_addr    <= word_addr(BASE_ADDR, index_next);
        end
        if (last_byte)
          last_pend <= 1'b1;
        else if (last_word)
          last_pend <= 1'b0;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      csum <= '0;
    else if (start_load)
      csum <= '0;
    else if (fire && state == S_DATA)
      csum <= csum ^ in_data;
  end
`endif

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory of the single-cycle RISC-V core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes each word through the instruction-memory write port starting at `BASE_ADDR`. It holds the CPU in reset until the whole program is loaded.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h1000: byte address of the first word written.
- `DEPTH_WORDS`, default 64: maximum program length in words.

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: asynchronous, active-low reset. This is already decided.
- `start` in 1: single-cycle pulse that begins a load.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader accepts a byte this cycle.
- `wr_en` out 1: instruction-memory write strobe, one cycle per word.
- `wr_addr` out 32: byte address of the word being written.
- `wr_data` out 32: word being written.
- `cpu_rst` out 1: active-high reset to the `cpu` block.
- `done` out 1: load complete.
- `error` out 1: load aborted.
- `word_count` out 16: number of words written so far.

## Operation
- A byte transfers on a rising edge where `in_valid && in_ready`.
- Frame format:
  - LEN_LO, then LEN_HI: N = 16-bit word count.
  - 4N payload bytes, least-significant byte first.
  - With the macro enabled, one checksum byte follows.
- FSM states and transitions:
  - IDLE: `in_ready`=0. `start` goes to LEN_LO and clears `word_count`, `done` and `error`.
  - LEN_LO: accept one byte, go to LEN_HI.
  - LEN_HI: accept one byte. If N > `DEPTH_WORDS`, go to ERR. If N == 0, go to CHECK (macro on) or DONE (macro off). Otherwise go to DATA.
  - DATA: a 2-bit byte counter fills a shift register. On the 4th byte the word is registered. The word index increments modulo N (no overrun). After word N-1, go to CHECK or DONE.
  - CHECK: accept one byte. Match goes to DONE; mismatch goes to ERR.
  - DONE: `done`=1, `cpu_rst`=0. `start` re-enters LEN_LO and reasserts `cpu_rst`.
  - ERR: `error`=1, `cpu_rst`=1, `in_ready`=0. Only `start` or `rst` exits.
- `start` is ignored in LEN_LO, LEN_HI, DATA and CHECK.
- `wr_addr` = `BASE_ADDR` + 4*index. The add is 32-bit and wraps modulo 2^32.
- `in_valid` low stalls any state indefinitely. No timeout.

## Timing
- Reset values:
  - `in_ready`=0, `wr_en`=0, `wr_addr`=`BASE_ADDR`, `wr_data`=0.
  - `cpu_rst`=1, `done`=0, `error`=0, `word_count`=0.
  - FSM in IDLE.
- `in_ready` is registered: it rises the cycle after entering LEN_LO.
- `wr_en` pulses for exactly one cycle, the cycle after the edge that accepts the 4th byte of a word. `wr_addr` and `wr_data` are stable during that cycle.
- `word_count` increments on the same edge that ends the `wr_en` cycle.
- `done` rises and `cpu_rst` falls one cycle after the final accepted byte, or after the final `wr_en` cycle, whichever is later.
- Throughput: one byte per cycle sustained.
- Asserting `rst` mid-load aborts immediately to reset values. No partial write is issued after `rst` asserts.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - A trailing byte equal to the XOR of all 4N payload bytes is required.
  - A mismatch sets `error` and keeps `cpu_rst` high.
  - Words already written are not retracted.
- Not defined: the CHECK state and its XOR accumulator are compiled out, and DATA goes directly to DONE.

## Structure
- A shared package holds:
  - the FSM state enum (IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR);
  - the reset constant for `wr_addr`;
  - the byte-lane count constant (4).
- One sub-module, `byte_to_word_packer`: 8-to-32 little-endian assembler with a 2-bit counter and a `word_valid` pulse.

## Test plan
- Normal load, macro off:
  - Stimulus: `start`, then bytes 04 00 03 A3 C4 FF 23 A4 64 00 33 E2 62 00 E3 0A 42 FE.
  - Required response: writes FFC4A303@1000, 0064A423@1004, 0062E233@1008, FE420AE3@100C. Then `done`=1, `cpu_rst`=0, `word_count`=4.
- Checksum, macro on:
  - Stimulus: the same frame plus byte 9E.
  - Required response: `done`=1.
  - Stimulus: the same frame plus byte 9F.
  - Required response: `error`=1, `cpu_rst` held 1, all 4 writes still seen.
- Oversize:
  - Stimulus: N = 0x0041 with `DEPTH_WORDS`=64.
  - Required response: ERR after LEN_HI, no `wr_en`, `in_ready`=0.
- Zero length:
  - Stimulus: bytes 00 00.
  - Required response: no `wr_en`, `done`=1 (macro off).
- Backpressure and stall:
  - Stimulus: `in_valid` toggled randomly across the 18-byte frame.
  - Required response: identical writes to the normal load. A `start` pulse mid-DATA is ignored.
- Reset mid-load:
  - Stimulus: `rst` low after 2 payload words.
  - Required response: all outputs return to reset values, no further `wr_en`. A subsequent `start` with a full frame reloads from `BASE_ADDR` 0x1000.
